// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the multicycle MIPS control path:
//     - opcode constants for the supported instruction classes
//     - ALU operation, ALU source-B and PC source encodings
//     - FSM state encodings (state_t)
//     - control word bundle (ctrl_t) produced by the output decoder
//   ADDIEX/ADDIWB encodings always exist here. They are only reachable when
//   MC_CONTROL_ADDI_EN is defined.
// ---------------------------------------------------------------------------
package mips_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU decoder request
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU source-B mux select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source mux select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM state encodings; 12..15 are unreachable and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  // Datapath control word (everything except the op-dependent illegal flag)
  typedef struct packed {
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic       alusrca;
    logic       irwrite;
    logic       memwrite;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_control_outdec.sv
// ---------------------------------------------------------------------------
// mc_control_outdec
//   Moore output decoder for the multicycle control FSM. Every control is a
//   function of the current state only, except irwrite/pcwrite in FETCH,
//   which follow memrdy so the PC/IR update only when the fetch completes.
//   Config: MC_CONTROL_ADDI_EN enables decoding of ADDIEX/ADDIWB.
// Ports:
//   state  in   current FSM state
//   memrdy in   memory access complete this cycle
//   ctrl   out  datapath control word
// ---------------------------------------------------------------------------
module mc_control_outdec
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   memrdy,
  output ctrl_t  ctrl
);

  always_comb begin
    // NOTE: default the whole word first so every unlisted control is 0 in
    // every state and no path through the case can infer a latch.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.irwrite = memrdy;
        ctrl.pcwrite = memrdy;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
`ifdef MC_CONTROL_ADDI_EN
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
`endif
      S_JEX: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//   Multicycle MIPS control FSM: state register and next-state logic. The
//   control outputs come from mc_control_outdec.
//   Config: define MC_CONTROL_ADDI_EN to support addi (op 001000). Without
//   it, addi is an illegal opcode.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset (forces FETCH)
//   op[5:0]   in   opcode, sampled only in DECODE and MEMADR
//   memrdy    in   memory access complete this cycle
//   memtoreg, regdst, iord, alusrca, irwrite, memwrite, pcwrite, branch,
//   regwrite  out  datapath controls
//   alusrcb[1:0], pcsrc[1:0]  out  mux selects
//   aluop[1:0] out 00 add, 01 sub, 10 use funct
//   illegal   out  one-cycle pulse in DECODE on an unsupported opcode
// ---------------------------------------------------------------------------
module mc_control_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memrdy,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic       alusrca,
  output logic       irwrite,
  output logic       memwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       regwrite,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal
);

  state_t state;
  state_t state_next;
  state_t decode_state;
  logic   illegal_op;
  ctrl_t  ctrl;

  // NOTE: sequential state uses non-blocking assignment; reset is sampled
  // on the clock edge and overrides every transition.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    illegal_op = 1'b0;
    case (state)
      S_FETCH:   state_next = memrdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
`ifdef MC_CONTROL_ADDI_EN
          OP_ADDI:      state_next = S_ADDIEX;
`endif
          OP_J:         state_next = S_JEX;
          default: begin
            state_next = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = memrdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   state_next = memrdy ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_RTYPEWB: state_next = S_FETCH;
      S_BEQEX:   state_next = S_FETCH;
`ifdef MC_CONTROL_ADDI_EN
      S_ADDIEX:  state_next = S_ADDIWB;
      S_ADDIWB:  state_next = S_FETCH;
`endif
      S_JEX:     state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  // While reset is held the outputs already look like FETCH, even before
  // the first edge has loaded the register.
  assign decode_state = reset ? S_FETCH : state;

  mc_control_outdec u_outdec (
    .state  (decode_state),
    .memrdy (memrdy),
    .ctrl   (ctrl)
  );

  assign memtoreg = ctrl.memtoreg;
  assign regdst   = ctrl.regdst;
  assign iord     = ctrl.iord;
  assign alusrca  = ctrl.alusrca;
  assign irwrite  = ctrl.irwrite;
  assign memwrite = ctrl.memwrite;
  assign pcwrite  = ctrl.pcwrite;
  assign branch   = ctrl.branch;
  assign regwrite = ctrl.regwrite;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;
  assign illegal  = illegal_op & ~reset;

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
//   Scoreboard bench for mc_control_fsm. The stimulus process drives one
//   cycle of inputs at a time and pushes the hand-derived output word for
//   that cycle. A monitor pops and compares it on the falling edge.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

  typedef struct packed {
    logic       illegal;
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic       alusrca;
    logic       irwrite;
    logic       memwrite;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } word_t;

  typedef struct {
    word_t w;
    string tag;
  } item_t;

  // Bench-local state tags for the expectation table
  localparam int FE = 0, DE = 1, MA = 2, MR = 3, MW = 4, WR = 5;
  localparam int RX = 6, RW = 7, BQ = 8, AX = 9, AW = 10, JX = 11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'b000000;
  logic       memrdy = 1'b1;
  logic       memtoreg, regdst, iord, alusrca, irwrite, memwrite;
  logic       pcwrite, branch, regwrite, illegal;
  logic [1:0] alusrcb, pcsrc, aluop;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .memrdy   (memrdy),
    .memtoreg (memtoreg),
    .regdst   (regdst),
    .iord     (iord),
    .alusrca  (alusrca),
    .irwrite  (irwrite),
    .memwrite (memwrite),
    .pcwrite  (pcwrite),
    .branch   (branch),
    .regwrite (regwrite),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .aluop    (aluop),
    .illegal  (illegal)
  );

  // Expected outputs per state, written out from the state table.
  function automatic word_t ex(int s, bit mr, bit il);
    word_t w = '0;
    case (s)
      FE: begin w.alusrcb = 2'b01; w.irwrite = mr; w.pcwrite = mr; end
      DE: begin w.alusrcb = 2'b11; w.illegal = il; end
      MA: begin w.alusrca = 1'b1; w.alusrcb = 2'b10; end
      MR: w.iord = 1'b1;
      MW: begin w.memtoreg = 1'b1; w.regwrite = 1'b1; end
      WR: begin w.iord = 1'b1; w.memwrite = 1'b1; end
      RX: begin w.alusrca = 1'b1; w.aluop = 2'b10; end
      RW: begin w.regdst = 1'b1; w.regwrite = 1'b1; end
      BQ: begin w.alusrca = 1'b1; w.aluop = 2'b01; w.pcsrc = 2'b01; w.branch = 1'b1; end
      AX: begin w.alusrca = 1'b1; w.alusrcb = 2'b10; end
      AW: w.regwrite = 1'b1;
      JX: begin w.pcsrc = 2'b10; w.pcwrite = 1'b1; end
      default: w = '0;
    endcase
    return w;
  endfunction

  // One cycle: drive inputs just after the rising edge, queue expectation.
  task automatic step(input bit rst, input logic [5:0] o, input bit mr,
                      input int s, input bit il, input string tag);
    item_t it;
    @(posedge clk);
    #1;
    reset  = rst;
    op     = o;
    memrdy = mr;
    it.w   = ex(s, mr, il);
    it.tag = tag;
    q.push_back(it);
  endtask

  // Monitor: compare whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      word_t act;
      it  = q.pop_front();
      act = {illegal, memtoreg, regdst, iord, alusrca, irwrite, memwrite,
             pcwrite, branch, regwrite, alusrcb, pcsrc, aluop};
      checks++;
      if (act !== it.w) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.tag, act, it.w);
      end
    end
  end

  initial begin
    // Reset held two cycles with memrdy=1 -> FETCH outputs
    step(1, 6'h00, 1, FE, 0, "reset_c1");
    step(1, 6'h00, 1, FE, 0, "reset_c2");

    // lw; op is junk in FETCH and changes in MEMRD, neither may matter
    step(0, 6'b111111, 1, FE, 0, "lw_fetch");
    step(0, 6'b100011, 1, DE, 0, "lw_decode");
    step(0, 6'b100011, 1, MA, 0, "lw_memadr");
    step(0, 6'b101011, 1, MR, 0, "lw_memrd");
    step(0, 6'b000000, 1, MW, 0, "lw_memwb");

    // FETCH stalls on memrdy=0, then sw with three wait cycles in MEMWR
    step(0, 6'b101011, 0, FE, 0, "sw_fetch_wait");
    step(0, 6'b101011, 1, FE, 0, "sw_fetch");
    step(0, 6'b101011, 1, DE, 0, "sw_decode");
    step(0, 6'b101011, 1, MA, 0, "sw_memadr");
    step(0, 6'b100011, 0, WR, 0, "sw_memwr_w1");
    step(0, 6'b100011, 0, WR, 0, "sw_memwr_w2");
    step(0, 6'b100011, 0, WR, 0, "sw_memwr_w3");
    step(0, 6'b100011, 1, WR, 0, "sw_memwr_done");

    // R-type
    step(0, 6'b000000, 1, FE, 0, "r_fetch");
    step(0, 6'b000000, 1, DE, 0, "r_decode");
    step(0, 6'b111111, 1, RX, 0, "r_ex");
    step(0, 6'b111111, 1, RW, 0, "r_wb");

    // beq
    step(0, 6'b000100, 1, FE, 0, "beq_fetch");
    step(0, 6'b000100, 1, DE, 0, "beq_decode");
    step(0, 6'b000100, 1, BQ, 0, "beq_ex");

    // j
    step(0, 6'b000010, 1, FE, 0, "j_fetch");
    step(0, 6'b000010, 1, DE, 0, "j_decode");
    step(0, 6'b000010, 1, JX, 0, "j_ex");

    // Unsupported opcode: one-cycle illegal pulse, FETCH next
    step(0, 6'b111111, 1, FE, 0, "ill_fetch");
    step(0, 6'b111111, 1, DE, 1, "ill_decode");
    step(0, 6'b111111, 1, FE, 0, "ill_back_fetch");

    // addi: supported only with the feature macro
    step(0, 6'b001000, 1, DE, `ifdef MC_CONTROL_ADDI_EN 0 `else 1 `endif, "addi_decode");
`ifdef MC_CONTROL_ADDI_EN
    step(0, 6'b001000, 1, AX, 0, "addi_ex");
    step(0, 6'b001000, 1, AW, 0, "addi_wb");
`endif

    // Reset in MEMRD while waiting on memory: FETCH, no regwrite later
    step(0, 6'b100011, 1, FE, 0, "rst_fetch");
    step(0, 6'b100011, 1, DE, 0, "rst_decode");
    step(0, 6'b100011, 1, MA, 0, "rst_memadr");
    step(0, 6'b100011, 0, MR, 0, "rst_memrd_wait");
    step(1, 6'b100011, 0, FE, 0, "rst_in_memrd");
    step(0, 6'b100011, 0, FE, 0, "rst_after_1");
    step(0, 6'b100011, 0, FE, 0, "rst_after_2");
    step(0, 6'b100011, 0, FE, 0, "rst_after_3");

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
